// File: rtl/friet_state_io_shell.sv
`default_nettype none
// ============================================================================
// Module   : friet_state_io_shell
// Purpose  : Serial load / multi-pass run / serial unload shell around a Friet
//            permutation core. Optional fault lock-out via the macro
//            FRIET_SHELL_FAULT_LOCK_EN.
// Revision : 1.0  initial release
// ============================================================================
module friet_state_io_shell #(
    parameter int STATE_SIZE    = 384,
    parameter int BUFFER_LENGTH = 8,
    parameter int PASS_W        = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [PASS_W-1:0]        passes,
    input  logic [BUFFER_LENGTH-1:0] data_in,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    output logic [BUFFER_LENGTH-1:0] data_out,
    output logic                     data_out_valid,
    input  logic                     data_out_ready,
    output logic                     finish,
    output logic                     core_free,
    output logic                     fault_detected,
    output logic                     core_start,
    output logic [STATE_SIZE-1:0]    core_state_out,
    input  logic [STATE_SIZE-1:0]    core_state_in,
    input  logic                     core_done,
    input  logic                     core_fault
);

    localparam int c_WORDS = STATE_SIZE / BUFFER_LENGTH;
    localparam int c_CNT_W = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_WORDS - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_LOAD      = 3'd1;
    localparam logic [2:0] c_FULL      = 3'd2;
    localparam logic [2:0] c_RUN_ISSUE = 3'd3;
    localparam logic [2:0] c_RUN_WAIT  = 3'd4;
    localparam logic [2:0] c_UNLOAD    = 3'd5;
    localparam logic [2:0] c_FAULT     = 3'd6;

    logic [2:0]                               r_fsm;
    logic [c_CNT_W-1:0]                       r_cnt;
    logic [c_WORDS-1:0][BUFFER_LENGTH-1:0]    r_state;
    logic [PASS_W-1:0]                        r_pass_cnt;
    logic                                     r_in_ready;
    logic                                     r_out_valid;
    logic                                     r_finish;
    logic                                     r_free;
    logic                                     r_fault;
    logic                                     r_core_start;
    logic                                     w_last_pass;

    assign w_last_pass    = (r_pass_cnt == PASS_W'(1));

    assign data_in_ready  = r_in_ready;
    assign data_out_valid = r_out_valid;
    assign finish         = r_finish;
    assign core_free      = r_free;
    assign fault_detected = r_fault;
    assign core_start     = r_core_start;
    assign core_state_out = r_state;
    // Word select is gated so the bus idles at zero outside UNLOAD.
    assign data_out       = r_out_valid ? r_state[r_cnt] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= c_IDLE;
            r_cnt        <= '0;
            r_state      <= '0;
            r_pass_cnt   <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_finish     <= 1'b0;
            r_free       <= 1'b1;
            r_fault      <= 1'b0;
            r_core_start <= 1'b0;
        end else begin
            r_finish     <= 1'b0;
            r_core_start <= 1'b0;
            case (r_fsm)
                c_IDLE, c_LOAD: begin
                    if (data_in_valid && r_in_ready) begin
                        r_state[r_cnt] <= data_in;
                        r_free         <= 1'b0;
                        if (r_cnt == c_LAST) begin
                            r_cnt      <= '0;
                            r_in_ready <= 1'b0;
                            r_fsm      <= c_FULL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            r_fsm <= c_LOAD;
                        end
                    end
                end
                c_FULL: begin
                    if (start) begin
                        r_pass_cnt   <= (passes == '0) ? PASS_W'(1) : passes;
                        r_core_start <= 1'b1;
                        r_fsm        <= c_RUN_ISSUE;
                    end
                end
                c_RUN_ISSUE: begin
                    r_fsm <= c_RUN_WAIT;
                end
                c_RUN_WAIT: begin
                    if (core_done) begin
                        r_state    <= core_state_in;
                        r_pass_cnt <= r_pass_cnt - 1'b1;
                        if (core_fault) begin
                            r_fault <= 1'b1;
                        end
`ifdef FRIET_SHELL_FAULT_LOCK_EN
                        if (core_fault) begin
                            r_state <= '0;
                            r_fsm   <= c_FAULT;
                        end else if (w_last_pass) begin
                            r_finish    <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_fsm       <= c_UNLOAD;
                        end else begin
                            r_core_start <= 1'b1;
                            r_fsm        <= c_RUN_ISSUE;
                        end
`else
                        if (w_last_pass) begin
                            r_finish    <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_fsm       <= c_UNLOAD;
                        end else begin
                            r_core_start <= 1'b1;
                            r_fsm        <= c_RUN_ISSUE;
                        end
`endif
                    end
                end
                c_UNLOAD: begin
                    if (data_out_ready) begin
                        if (r_cnt == c_LAST) begin
                            r_cnt       <= '0;
                            r_state     <= '0;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_free      <= 1'b1;
                            r_fsm       <= c_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_FAULT: begin
                    // Terminal until reset; every handshake stays closed.
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
                default: begin
                    r_fsm <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_friet_state_io_shell.sv
`default_nettype none
// ============================================================================
// Module   : tb_friet_state_io_shell
// Purpose  : Self-checking bench for friet_state_io_shell with a core model.
// Revision : 1.0  initial release
// ============================================================================
module tb_friet_state_io_shell;

    localparam int WORDS    = 48;
    localparam int CORE_LAT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   passes = 3'd0;
    logic [7:0]   data_in = 8'd0;
    logic         data_in_valid = 1'b0;
    logic         data_out_ready = 1'b0;
    logic [383:0] core_state_in = '0;
    logic         core_done = 1'b0;
    logic         core_fault = 1'b0;
    wire          data_in_ready, data_out_valid, finish, core_free;
    wire          fault_detected, core_start;
    wire  [7:0]   data_out;
    wire  [383:0] core_state_out;

    int total = 0;
    int bad = 0;
    logic [7:0] in_w [WORDS];

    always #5 clk = ~clk;

    friet_state_io_shell dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .passes         (passes),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .finish         (finish),
        .core_free      (core_free),
        .fault_detected (fault_detected),
        .core_start     (core_start),
        .core_state_out (core_state_out),
        .core_state_in  (core_state_in),
        .core_done      (core_done),
        .core_fault     (core_fault)
    );

    // Core model: inverts the state, done CORE_LAT cycles after the start cycle.
    int cd_cnt = 0;
    int pass_num = 0;
    int fault_pass = 0;
    always @(posedge clk) begin
        core_done  <= 1'b0;
        core_fault <= 1'b0;
        if (rst) begin
            cd_cnt <= 0;
        end else if (core_start) begin
            cd_cnt        <= CORE_LAT;
            core_state_in <= ~core_state_out;
        end else if (cd_cnt > 0) begin
            cd_cnt <= cd_cnt - 1;
            if (cd_cnt == 1) begin
                core_done  <= 1'b1;
                core_fault <= (pass_num + 1 == fault_pass);
                pass_num   <= pass_num + 1;
            end
        end
        if (rst || core_free) pass_num <= 0;
    end

    int cyc = 0;
    int starts_seen = 0;
    int finish_seen = 0;
    int start_cyc [$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_start) begin
            starts_seen <= starts_seen + 1;
            start_cyc.push_back(cyc);
        end
        if (finish) finish_seen <= finish_seen + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_seq();
        for (int i = 0; i < WORDS; i++) in_w[i] = 8'(i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < WORDS; i++) in_w[i] = 8'($urandom);
    endtask

    task automatic do_reset();
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        start          = 1'b0;
        rst            = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",   data_in_ready, 1);
        chk("rst_core_free",  core_free, 1);
        chk("rst_out_valid",  data_out_valid, 0);
        chk("rst_finish",     finish, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_fault",      fault_detected, 0);
        chk("rst_data_out",   data_out, 0);
        chk("rst_state_out",  core_state_out, 0);
        rst = 1'b0;
    endtask

    task automatic load_state(input bit gaps, input int start_at);
        int k = 0;
        int n = 0;
        int s0 = starts_seen;
        logic [383:0] m = '0;
        while (k < WORDS && n < 1000) begin
            data_in       = in_w[k];
            data_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            start         = (k == start_at);
            if (data_in_valid && data_in_ready) k++;
            @(negedge clk);
            n++;
        end
        data_in_valid = 1'b0;
        start         = 1'b0;
        for (int i = 0; i < WORDS; i++) m[i*8 +: 8] = in_w[i];
        chk("load_words", 384'(k), 384'(WORDS));
        if (!gaps) chk("load_cycles", 384'(n), 384'(WORDS));
        chk("load_ready_low", data_in_ready, 0);
        chk("load_no_start", 384'(starts_seen), 384'(s0));
        chk("load_state", core_state_out, m);
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random; abort_at >= 0 resets mid-unload
    task automatic run_unload(input int p, input int rmode, input int abort_at);
        int eff = (p == 0) ? 1 : p;
        int s0 = starts_seen;
        int f0 = finish_seen;
        int q0 = start_cyc.size();
        int n = 0;
        int k = 0;
        int ph = 0;
        logic [7:0] ew;
        passes = 3'(p);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        passes = 3'($urandom);
        chk("start_next_cycle", core_start, 1);
        while (!data_out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("finish_with_valid", finish, 1);
        while (k < WORDS && k != abort_at && n < 3000) begin
            data_out_ready = (rmode == 0) ? 1'b1 :
                             (rmode == 1) ? ((ph % 4 == 0) || (ph % 4 == 3)) :
                             1'($urandom_range(0, 1));
            ew = (eff % 2 == 1) ? ~in_w[k] : in_w[k];
            chk("dout_valid", data_out_valid, 1);
            chk($sformatf("dout_word%0d", k), data_out, ew);
            if (data_out_ready) k++;
            @(negedge clk);
            n++;
            ph++;
        end
        data_out_ready = 1'b0;
        if (abort_at >= 0) begin
            rst = 1'b1;
            @(negedge clk);
            chk("abort_out_valid", data_out_valid, 0);
            chk("abort_core_free", core_free, 1);
            do_reset();
            return;
        end
        chk("unload_words", 384'(k), 384'(WORDS));
        chk("unload_valid_low", data_out_valid, 0);
        chk("unload_in_ready", data_in_ready, 1);
        chk("unload_core_free", core_free, 1);
        chk("unload_state_clr", core_state_out, 0);
        chk("pass_count", 384'(starts_seen - s0), 384'(eff));
        chk("finish_count", 384'(finish_seen - f0), 384'(1));
        for (int i = 1; i < eff; i++) begin
            if (q0 + i < start_cyc.size())
                chk("pass_gap", 384'(start_cyc[q0+i] - start_cyc[q0+i-1]), 384'(CORE_LAT + 2));
        end
    endtask

    initial begin
        int s0;
        int f0;
        bit vseen;
        @(negedge clk);
        do_reset();

        fill_seq();
        load_state(1'b0, -1);
        run_unload(1, 0, -1);

        load_state(1'b0, -1);
        run_unload(3, 0, -1);

        fill_rand();
        load_state(1'b1, 10);
        run_unload(0, 2, -1);

        fill_rand();
        load_state(1'b1, -1);
        run_unload(2, 1, -1);

        fault_pass = 2;
        fill_rand();
        load_state(1'b0, -1);
`ifdef FRIET_SHELL_FAULT_LOCK_EN
        s0     = starts_seen;
        f0     = finish_seen;
        vseen  = 1'b0;
        passes = 3'd3;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (data_out_valid) vseen = 1'b1;
        end
        chk("lock_fault", fault_detected, 1);
        chk("lock_no_finish", 384'(finish_seen - f0), 384'(0));
        chk("lock_no_valid", vseen, 0);
        chk("lock_in_ready", data_in_ready, 0);
        chk("lock_starts", 384'(starts_seen - s0), 384'(2));
        chk("lock_zeroised", core_state_out, 0);
        fault_pass = 0;
        do_reset();
        fill_rand();
        load_state(1'b0, -1);
        run_unload(1, 0, -1);
`else
        s0    = starts_seen;
        f0    = finish_seen;
        vseen = 1'b0;
        run_unload(3, 0, -1);
        chk("char_fault", fault_detected, 1);
        chk("char_fault_sticky_src", 384'(starts_seen - s0 + finish_seen - f0 + 32'(vseen)), 384'(4));
        fault_pass = 0;
        do_reset();
`endif

        fill_rand();
        load_state(1'b0, -1);
        run_unload(1, 0, 20);
        fill_rand();
        load_state(1'b1, -1);
        run_unload(1, 2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/friet_state_io_shell.md
# friet_state_io_shell

Parametrised serial-to-parallel communication shell around a Friet permutation core. It loads a STATE_SIZE-bit state over a BUFFER_LENGTH-bit valid/ready stream and starts the core for a programmable number of back-to-back permutation passes. It then unloads the result over a second valid/ready stream. Compared with the fixed 384-bit/single-pass wrapper, it generalises state and bus width, adds multi-pass chaining and backpressure on unload, and adds a fault lock-out path.

## Interface
- STATE_SIZE, 384, state width in bits; must be a multiple of BUFFER_LENGTH.
- BUFFER_LENGTH, 8, serial word width. WORDS = STATE_SIZE/BUFFER_LENGTH.
- PASS_W, 3, width of the passes input.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin processing; honoured only in FULL.
- passes  in  PASS_W  number of permutation passes, sampled with start; 0 is treated as 1.
- data_in  in  BUFFER_LENGTH  input word.
- data_in_valid  in  1  data_in qualifier.
- data_in_ready  out  1  shell accepts a word this cycle.
- data_out  out  BUFFER_LENGTH  output word.
- data_out_valid  out  1  data_out qualifier.
- data_out_ready  in  1  consumer accepts data_out.
- finish  out  1  one-cycle pulse when the last pass completes.
- core_free  out  1  shell idle, no state held.
- fault_detected  out  1  sticky fault flag.
- core_start  out  1  one-cycle start pulse to the permutation core.
- core_state_out  out  STATE_SIZE  state presented to the core.
- core_state_in  in  STATE_SIZE  core result, valid with core_done.
- core_done  in  1  one-cycle completion pulse from the core.
- core_fault  in  1  core fault indication, sampled with core_done.

## Operation
- FSM states: IDLE, LOAD, FULL, RUN_ISSUE, RUN_WAIT, UNLOAD, FAULT.
- IDLE/LOAD:
  - data_in_ready = 1.
  - On data_in_valid & data_in_ready, word k is written to state[k*BUFFER_LENGTH +: BUFFER_LENGTH], LSB word first, and the word counter increments.
  - The first word moves the FSM IDLE->LOAD.
  - Word WORDS-1 moves the FSM to FULL.
  - The counter wraps to 0.
- FULL: data_in_ready = 0. On start, latch pass_cnt = max(passes,1) and go to RUN_ISSUE. start in any other state is ignored.
- RUN_ISSUE: core_start = 1 for one cycle, then RUN_WAIT. core_state_out always equals the state register.
- RUN_WAIT, on core_done:
  - Capture core_state_in into the state register and decrement pass_cnt.
  - If the core faulted, take the fault action (see Configuration).
  - Else, if pass_cnt becomes 0, go to UNLOAD with finish = 1 for that cycle.
  - Else, go to RUN_ISSUE.
- UNLOAD:
  - data_out = state[k*BUFFER_LENGTH +: BUFFER_LENGTH], LSB word first.
  - data_out_valid = 1.
  - The word counter advances only on data_out_valid & data_out_ready.
  - After word WORDS-1 is accepted, the state register is cleared and the FSM goes to IDLE.
- core_free = 1 only in IDLE.
- fault_detected stays set until rst.
- rst mid-operation: synchronous return to IDLE, counters and state cleared, fault_detected cleared, any in-flight core_done ignored.

## Timing
- Output values in the cycle after rst is sampled high:
  - data_in_ready = 1 and core_free = 1.
  - data_out_valid, finish, core_start and fault_detected = 0.
  - data_out = 0 and core_state_out = 0.
- Minimum load: WORDS cycles with continuous valid. data_in_ready falls the cycle after the last word is accepted.
- start accepted in FULL: core_start is high in the next cycle.
- core_done must arrive no earlier than one cycle after core_start.
- Pass chaining: core_done is followed by the next core_start one cycle later, so each pass adds 2 overhead cycles.
- finish and the first data_out_valid occur in the same cycle; that cycle is one cycle after the final core_done.
- Unload: WORDS cycles minimum. data_out is held stable while data_out_valid & !data_out_ready.
- Back-to-back operation: data_in_ready is 1 in the cycle after the last output word is accepted.

## Configuration
- FRIET_SHELL_FAULT_LOCK_EN defined:
  - core_fault & core_done sets fault_detected, zeroises the state register and enters FAULT.
  - FAULT is terminal until rst: data_in_ready = 0, data_out_valid = 0, finish never pulses, core_start = 0.
- Undefined (characterisation build):
  - core_fault & core_done sets fault_detected only.
  - The state is captured and processing continues normally.

## Test plan
- Reset, then load 48 bytes 0x00..0x2F with continuous valid, passes=1, using a core model that returns state XOR all-ones 3 cycles after core_start -> core_start exactly once; unloaded bytes 0xFF..0xD0 in order; finish pulses once.
- Same load, passes=3 -> three core_start pulses each 5 cycles apart (3 cycles core latency + 2 overhead); output equals input XOR all-ones (odd number of passes).
- passes=0 -> behaves as passes=1. start pulsed in LOAD after 10 words -> ignored; no core_start.
- Unload with data_out_ready toggling 1,0,0,1 -> data_out held during stalls; all 48 words delivered exactly once, none duplicated.
- core_fault asserted with core_done on pass 2 of 3:
  - With the macro: fault_detected = 1, no finish, data_out_valid stays 0; after rst, fault_detected = 0 and a new load succeeds.
  - Without the macro: fault_detected = 1 and a full unload occurs.
- rst asserted mid-UNLOAD at word 20 -> next cycle data_out_valid = 0, core_free = 1; a subsequent load and unload are correct.
